// File: rtl/eth_fifo_arb_pkg.sv
// Shared types and the round-robin pick function for the GIG_ETH FIFO write arbiter.
package eth_fifo_arb_pkg;

    // Largest supported requester count; the pick function works on this width.
    localparam int unsigned MAX_SRC = 8;
    localparam int unsigned PICK_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, searching upward and wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [PICK_W-1:0]  ptr,
        input int unsigned        n
    );
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            if ((i < n) && !res.found) begin
                cand = (32'(ptr) + i) % n;
                if (req[cand[PICK_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[PICK_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/eth_fifo_wr_arb_rr_arbiter.sv
// Combinational round-robin picker; the rotating pointer lives in the parent.
module rr_arbiter
    import eth_fifo_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic               found,
    output logic [SRC_W-1:0]   idx
);

    logic [MAX_SRC-1:0] req_ext;
    logic [PICK_W-1:0]  ptr_ext;
    rr_pick_t           res;

    // Widen to the package pick width, pick, then narrow back to SRC_W.
    always_comb begin
        req_ext                 = '0;
        req_ext[NUM_SRC-1:0]    = req;
        ptr_ext                 = '0;
        ptr_ext[SRC_W-1:0]      = ptr;
        res                     = rr_pick(req_ext, ptr_ext, NUM_SRC);
        // Range guard also keeps every bit of the wide index in use.
        found                   = res.found && ({1'b0, res.idx} < 4'(NUM_SRC));
        idx                     = res.idx[SRC_W-1:0];
    end

endmodule

// File: rtl/eth_fifo_wr_arb.sv
// Frame-granular round-robin arbiter for the shared write port of one sync FIFO.
// A source is granted only when a worst-case frame fits, and keeps the grant to last.
module eth_fifo_wr_arb
    import eth_fifo_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2048,
    parameter int MAX_FRAME  = 1536,
    parameter int WCNT_WIDTH = $clog2(FIFO_DEPTH) + 1,
    parameter int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            s_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SRC-1:0]            s_last,
    output logic [NUM_SRC-1:0]            s_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH+SRC_W:0]     fifo_din,
    input  logic                          fifo_full,
    input  logic [WCNT_WIDTH-1:0]         fifo_wr_data_count,
    input  logic                          fifo_wr_rst_busy,
    output logic                          grant_vld,
    output logic [SRC_W-1:0]              grant_id,
    output logic [15:0]                   frame_cnt
);

    localparam int CW = WCNT_WIDTH + 1;

    arb_state_t            state;
    logic [SRC_W-1:0]      rr_ptr;
    logic                  pick_found;
    logic [SRC_W-1:0]      pick_idx;
    logic [CW-1:0]         depth_ext;
    logic [CW-1:0]         cnt_ext;
    logic [CW-1:0]         room;
    logic                  space_ok;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic [SRC_W-1:0]      next_ptr;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr (
        .req   (s_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Room check one bit wider than the count so the subtraction cannot wrap.
    always_comb begin
        depth_ext = CW'(FIFO_DEPTH);
        cnt_ext   = {1'b0, fifo_wr_data_count};
        room      = depth_ext - cnt_ext;
        space_ok  = (cnt_ext <= depth_ext) && (room >= CW'(MAX_FRAME));
    end

    // Select the granted source's beat.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_id == SRC_W'(i)) begin
                sel_valid = s_valid[i];
                sel_last  = s_last[i];
                sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready only to the granted source, stalled by full or FIFO reset; data path is zero-latency.
    always_comb begin
        accept  = (state == XFER) && !fifo_full && !fifo_wr_rst_busy;
        s_ready = '0;
        if (accept) begin
            s_ready[grant_id] = 1'b1;
        end
        fifo_wr_en = accept && sel_valid;
        fifo_din   = {grant_id, sel_last, sel_data};
        next_ptr   = (grant_id == SRC_W'(NUM_SRC - 1)) ? '0 : grant_id + SRC_W'(1);
    end

    // Grant FSM: pick a winner in IDLE when a full frame fits, release on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && !fifo_wr_rst_busy && space_ok) begin
                        state     <= XFER;
                        grant_id  <= pick_idx;
                        grant_vld <= 1'b1;
                    end
                end
                XFER: begin
                    if (fifo_wr_en && sel_last) begin
                        state     <= IDLE;
                        grant_vld <= 1'b0;
                        rr_ptr    <= next_ptr;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_fifo_wr_arb.sv
// Directed bench for eth_fifo_wr_arb with default parameters (4 sources, 8-bit data).
module tb_eth_fifo_wr_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_last;
    logic [3:0]  s_ready;
    logic        fifo_wr_en;
    logic [10:0] fifo_din;
    logic        fifo_full;
    logic [11:0] fifo_wr_data_count;
    logic        fifo_wr_rst_busy;
    logic        grant_vld;
    logic [1:0]  grant_id;
    logic [15:0] frame_cnt;

    int vectors;
    int miscompares;

    eth_fifo_wr_arb #(
        .NUM_SRC    (4),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (2048),
        .MAX_FRAME  (1536),
        .WCNT_WIDTH (12),
        .SRC_W      (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_valid            (s_valid),
        .s_data             (s_data),
        .s_last             (s_last),
        .s_ready            (s_ready),
        .fifo_wr_en         (fifo_wr_en),
        .fifo_din           (fifo_din),
        .fifo_full          (fifo_full),
        .fifo_wr_data_count (fifo_wr_data_count),
        .fifo_wr_rst_busy   (fifo_wr_rst_busy),
        .grant_vld          (grant_vld),
        .grant_id           (grant_id),
        .frame_cnt          (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int src, input int d);
        s_data[src*8 +: 8] = 8'(d);
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        s_valid            = '0;
        s_last             = '0;
        s_data             = '0;
        fifo_full          = 1'b0;
        fifo_wr_data_count = '0;
        fifo_wr_rst_busy   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int g;
        int k;
        vectors     = 0;
        miscompares = 0;

        // Reset with FIFO reset busy and every source requesting
        rst_n              = 1'b0;
        s_valid            = 4'hF;
        s_last             = '0;
        s_data             = '0;
        fifo_full          = 1'b0;
        fifo_wr_data_count = '0;
        fifo_wr_rst_busy   = 1'b1;
        #1;
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_grant_vld", 32'(grant_vld), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            #1;
            chk("busy_ready", 32'(s_ready), 0);
            chk("busy_wr_en", 32'(fifo_wr_en), 0);
        end
        tick();
        fifo_wr_rst_busy = 1'b0;
        #1;
        chk("busy_drop_ready", 32'(s_ready), 0);
        tick();
        #1;
        chk("busy_grant_vld", 32'(grant_vld), 1);
        chk("busy_grant_id", 32'(grant_id), 0);
        chk("busy_grant_ready", 32'(s_ready), 32'h1);
        s_last = 4'hF;
        #1;
        chk("busy_first_wr", 32'(fifo_wr_en), 1);
        tick();
        s_valid = '0;
        s_last  = '0;
        #1;
        chk("busy_frame_cnt", 32'(frame_cnt), 1);

        // Round-robin: all sources offer 3-beat frames continuously
        do_reset();
        s_valid = 4'hF;
        s_last  = '0;
        #1;
        chk("rr_start_ready", 32'(s_ready), 0);
        for (int f = 0; f < 8; f++) begin
            g = f % 4;
            tick();
            for (int b = 0; b < 3; b++) begin
                if (b > 0) tick();
                s_last = (b == 2) ? 4'hF : 4'h0;
                for (int src = 0; src < 4; src++) set_data(src, src * 16 + b);
                #1;
                chk("rr_grant_id", 32'(grant_id), 32'(g));
                chk("rr_ready", 32'(s_ready), 32'(1 << g));
                chk("rr_wr_en", 32'(fifo_wr_en), 1);
                chk("rr_din", 32'(fifo_din), 32'((g << 9) | ((b == 2 ? 1 : 0) << 8) | (g * 16 + b)));
            end
            tick();
            s_last = '0;
            #1;
            chk("rr_gap_vld", 32'(grant_vld), 0);
            chk("rr_gap_ready", 32'(s_ready), 0);
            chk("rr_frame_cnt", 32'(frame_cnt), 32'(f + 1));
        end

        // Backpressure: 64-beat frame from source 2, full for 5 cycles mid-frame
        do_reset();
        s_valid = 4'b0100;
        #1;
        chk("bp_idle_ready", 32'(s_ready), 0);
        tick();
        k = 0;
        for (int cyc = 0; cyc < 69; cyc++) begin
            if (cyc > 0) tick();
            fifo_full = (cyc >= 20 && cyc < 25);
            if (cyc == 3) s_valid = 4'b0101;
            set_data(2, k);
            set_data(0, 8'hEE);
            s_last = (k == 63) ? 4'b0100 : 4'b0000;
            #1;
            chk("bp_ready", 32'(s_ready), fifo_full ? 32'h0 : 32'h4);
            chk("bp_wr_en", 32'(fifo_wr_en), fifo_full ? 32'h0 : 32'h1);
            if (!fifo_full) begin
                chk("bp_din", 32'(fifo_din), 32'((2 << 9) | ((k == 63 ? 1 : 0) << 8) | k));
                k++;
            end
        end
        tick();
        fifo_full = 1'b0;
        s_valid   = '0;
        s_last    = '0;
        #1;
        chk("bp_end_vld", 32'(grant_vld), 0);
        chk("bp_frame_cnt", 32'(frame_cnt), 1);

        // Space gate: one word short of room, then exactly enough
        do_reset();
        fifo_wr_data_count = 12'd513;
        s_valid = 4'b0010;
        s_last  = 4'b0010;
        set_data(1, 8'h77);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            chk("gate_vld", 32'(grant_vld), 0);
            chk("gate_ready", 32'(s_ready), 0);
        end
        tick();
        fifo_wr_data_count = 12'd512;
        #1;
        chk("gate_drop_ready", 32'(s_ready), 0);
        tick();
        #1;
        chk("gate_grant_vld", 32'(grant_vld), 1);
        chk("gate_grant_id", 32'(grant_id), 1);
        chk("gate_ready_open", 32'(s_ready), 32'h2);
        chk("gate_din", 32'(fifo_din), 32'h377);
        tick();
        s_valid = '0;
        fifo_wr_data_count = '0;
        #1;
        chk("gate_frame_cnt", 32'(frame_cnt), 1);

        // Stalled source: source 0 goes quiet mid-frame while source 3 waits
        do_reset();
        s_valid = 4'b0001;
        s_last  = '0;
        #1;
        tick();
        set_data(0, 8'h10);
        #1;
        chk("stall_grant", 32'(grant_id), 0);
        chk("stall_din0", 32'(fifo_din), 32'h010);
        tick();
        set_data(0, 8'h11);
        #1;
        chk("stall_wr1", 32'(fifo_wr_en), 1);
        tick();
        s_valid = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            #1;
            chk("stall_hold_id", 32'(grant_id), 0);
            chk("stall_hold_ready", 32'(s_ready), 32'h1);
            chk("stall_hold_wr", 32'(fifo_wr_en), 0);
        end
        tick();
        s_valid = 4'b1001;
        s_last  = 4'b0001;
        set_data(0, 8'h12);
        #1;
        chk("stall_last_wr", 32'(fifo_wr_en), 1);
        chk("stall_last_din", 32'(fifo_din), 32'h112);
        tick();
        s_valid = 4'b1000;
        s_last  = '0;
        #1;
        chk("stall_gap_ready", 32'(s_ready), 0);
        chk("stall_frame_cnt", 32'(frame_cnt), 1);
        tick();
        #1;
        chk("stall_next_id", 32'(grant_id), 3);
        chk("stall_next_ready", 32'(s_ready), 32'h8);

        // Asynchronous reset on beat 5 of a 10-beat frame
        do_reset();
        s_valid = 4'b0010;
        s_last  = 4'b0010;
        set_data(1, 8'h5A);
        #1;
        tick();
        #1;
        chk("ar_pre_din", 32'(fifo_din), 32'h35A);
        tick();
        s_valid = 4'b0001;
        s_last  = '0;
        #1;
        chk("ar_pre_cnt", 32'(frame_cnt), 1);
        tick();
        for (int b = 0; b < 5; b++) begin
            if (b > 0) tick();
            set_data(0, 32 + b);
            #1;
            chk("ar_beat_id", 32'(grant_id), 0);
            chk("ar_beat_wr", 32'(fifo_wr_en), 1);
        end
        rst_n = 1'b0;
        #1;
        chk("ar_ready", 32'(s_ready), 0);
        chk("ar_wr_en", 32'(fifo_wr_en), 0);
        chk("ar_grant_vld", 32'(grant_vld), 0);
        chk("ar_frame_cnt", 32'(frame_cnt), 0);
        tick();
        tick();
        s_valid = 4'hF;
        rst_n   = 1'b1;
        #1;
        chk("ar_rel_ready", 32'(s_ready), 0);
        tick();
        #1;
        chk("ar_rel_vld", 32'(grant_vld), 1);
        chk("ar_rel_id", 32'(grant_id), 0);
        chk("ar_rel_ready1", 32'(s_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
